// File: rtl/ram2p_pmem_x16_if.sv
// ram2p_pmem_x16_if: bus bundle for the dual-port AVR program memory.
// Port A (pm_*) is the loader/self-programming read/write port.
// Port B (pm_core_*) is the core's read-only instruction-fetch port.
// The master modport drives addresses and write data.
// The slave modport is the memory side.
interface ram2p_pmem_x16_if;
    logic [16:0] pm_addr;
    logic        pm_ce;
    logic        pm_wr;
    logic [15:0] pm_wr_data;
    logic [15:0] pm_rd_data;
    logic [16:0] pm_core_rd_addr;
    logic [15:0] pm_core_rd_data;
    logic        pm_addr_err;
    logic        pm_core_addr_err;

    modport master (
        output pm_addr, pm_ce, pm_wr, pm_wr_data, pm_core_rd_addr,
        input  pm_rd_data, pm_core_rd_data, pm_addr_err, pm_core_addr_err
    );

    modport slave (
        input  pm_addr, pm_ce, pm_wr, pm_wr_data, pm_core_rd_addr,
        output pm_rd_data, pm_core_rd_data, pm_addr_err, pm_core_addr_err
    );
endinterface

// File: rtl/ram2p_pmem_x16.sv
// ram2p_pmem_x16: dual-port 16-bit program memory (PM_SIZE K-words).
// Port A is read/write and gated by pm_ce. Port B fetches every cycle.
// Both ports have one cycle of read latency.
// A same-address port B read during a port A write returns the old word.
// Optional feature: define PMEM_RANGE_CHECK_EN to build the address-range
// error flags. When it is undefined, both flags are tied to 0.
module ram2p_pmem_x16 #(
    parameter int PM_SIZE = 16
) (
    input  logic             clk,
    input  logic             rst_flash_n,
    ram2p_pmem_x16_if.slave  pm
);
    localparam int PM_DEPTH = PM_SIZE * 1024;
    localparam int ADDR_W   = $clog2(PM_DEPTH);

    // Storage has no reset, so it can map onto block RAM.
    logic [15:0] mem [PM_DEPTH];

    // Upper address bits are dropped, so addresses wrap modulo PM_DEPTH.
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              wr_en;
    logic              rd_en_a;
    logic [15:0]       rd_data_q;
    logic [15:0]       core_rd_data_q;

    assign addr_a  = pm.pm_addr[ADDR_W-1:0];
    assign addr_b  = pm.pm_core_rd_addr[ADDR_W-1:0];
    // A write is suppressed while reset is held low.
    // This also drops a write that is in flight when reset arrives.
    assign wr_en   = rst_flash_n & pm.pm_ce & pm.pm_wr;
    assign rd_en_a = pm.pm_ce & ~pm.pm_wr;

    // Port A write into the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_a] <= pm.pm_wr_data;
        end
    end

    // Port A registered read. The register holds on writes and when idle.
    always_ff @(posedge clk or negedge rst_flash_n) begin
        if (!rst_flash_n) begin
            rd_data_q <= 16'h0000;
        end else if (rd_en_a) begin
            rd_data_q <= mem[addr_a];
        end
    end

    // Port B registered fetch on every cycle.
    // Because the write above is a non-blocking update, this read sees
    // the old word on a same-address collision.
    always_ff @(posedge clk or negedge rst_flash_n) begin
        if (!rst_flash_n) begin
            core_rd_data_q <= 16'h0000;
        end else begin
            core_rd_data_q <= mem[addr_b];
        end
    end

    assign pm.pm_rd_data      = rd_data_q;
    assign pm.pm_core_rd_data = core_rd_data_q;

`ifdef PMEM_RANGE_CHECK_EN
    // The fetch limit sits one word past the end, so the core may
    // prefetch a single word beyond the last instruction without an error.
    localparam logic [16:0] A_LAST  = 17'(PM_DEPTH - 1);
    localparam logic [16:0] B_LIMIT = 17'(PM_DEPTH);

    logic addr_err_d;
    logic core_addr_err_d;
    logic addr_err_q;
    logic core_addr_err_q;

    // Range comparators for the next error-flag values.
    always_comb begin
        addr_err_d      = 1'b0;
        core_addr_err_d = 1'b0;
        if (pm.pm_ce && (pm.pm_addr > A_LAST)) begin
            addr_err_d = 1'b1;
        end
        if (pm.pm_core_rd_addr > B_LIMIT) begin
            core_addr_err_d = 1'b1;
        end
    end

    // Error flags are single-cycle pulses that line up with the read data.
    always_ff @(posedge clk or negedge rst_flash_n) begin
        if (!rst_flash_n) begin
            addr_err_q      <= 1'b0;
            core_addr_err_q <= 1'b0;
        end else begin
            addr_err_q      <= addr_err_d;
            core_addr_err_q <= core_addr_err_d;
        end
    end

    assign pm.pm_addr_err      = addr_err_q;
    assign pm.pm_core_addr_err = core_addr_err_q;

`ifndef SYNTHESIS
    // Report the offending address from the instance path.
    // The access itself still goes ahead.
    always_ff @(posedge clk) begin
        if (rst_flash_n && addr_err_d) begin
            $warning("%m: port A address 0x%05h out of range", pm.pm_addr);
        end
        if (rst_flash_n && core_addr_err_d) begin
            $warning("%m: port B address 0x%05h out of range", pm.pm_core_rd_addr);
        end
    end
`endif
`else
    // With no checker built, the upper address bits are intentionally unused.
    logic unused_addr_hi;
    assign unused_addr_hi      = ^{pm.pm_addr[16:ADDR_W], pm.pm_core_rd_addr[16:ADDR_W]};
    assign pm.pm_addr_err      = 1'b0;
    assign pm.pm_core_addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram2p_pmem_x16.sv
// tb_ram2p_pmem_x16: directed test of ram2p_pmem_x16 at PM_SIZE=16 and PM_SIZE=32.
// The expected error flags depend on whether PMEM_RANGE_CHECK_EN is defined.
module tb_ram2p_pmem_x16;
`ifdef PMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_flash_n = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    ram2p_pmem_x16_if if16 ();
    ram2p_pmem_x16_if if32 ();

    ram2p_pmem_x16 #(.PM_SIZE(16)) dut16 (.clk(clk), .rst_flash_n(rst_flash_n), .pm(if16.slave));
    ram2p_pmem_x16 #(.PM_SIZE(32)) dut32 (.clk(clk), .rst_flash_n(rst_flash_n), .pm(if32.slave));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a16(input logic ce, input logic wr, input logic [16:0] addr, input logic [15:0] data);
        if16.pm_ce      = ce;
        if16.pm_wr      = wr;
        if16.pm_addr    = addr;
        if16.pm_wr_data = data;
    endtask

    task automatic a32(input logic ce, input logic wr, input logic [16:0] addr, input logic [15:0] data);
        if32.pm_ce      = ce;
        if32.pm_wr      = wr;
        if32.pm_addr    = addr;
        if32.pm_wr_data = data;
    endtask

    initial begin
        a16(1'b0, 1'b0, 17'h0, 16'h0);
        a32(1'b0, 1'b0, 17'h0, 16'h0);
        if16.pm_core_rd_addr = 17'h0;
        if32.pm_core_rd_addr = 17'h0;

        // Reset state.
        tick(); tick();
        check_eq("rst rd_data",       if16.pm_rd_data, 32'h0);
        check_eq("rst core_rd_data",  if16.pm_core_rd_data, 32'h0);
        check_eq("rst addr_err",      if16.pm_addr_err, 32'h0);
        check_eq("rst core_addr_err", if16.pm_core_addr_err, 32'h0);
        rst_flash_n = 1'b1;

        // Preload the words used by later tests.
        a16(1'b1, 1'b1, 17'h00123, 16'hA5C3); tick();
        a16(1'b1, 1'b1, 17'h00040, 16'h2222); tick();
        a16(1'b1, 1'b1, 17'h00201, 16'h5555); tick();
        a16(1'b1, 1'b1, 17'h00000, 16'h0F0F); tick();
        a16(1'b1, 1'b1, 17'h00001, 16'h1357); tick();
        a16(1'b1, 1'b1, 17'h03FFF, 16'hC0DE); tick();

        // Write then read on both ports.
        a16(1'b1, 1'b0, 17'h00123, 16'h0);
        if16.pm_core_rd_addr = 17'h00123;
        tick();
        check_eq("wr/rd portA 0x123", if16.pm_rd_data, 32'hA5C3);
        check_eq("wr/rd portB 0x123", if16.pm_core_rd_data, 32'hA5C3);

        // Collision: port B sees the old word, then the new word one cycle later.
        a16(1'b1, 1'b1, 17'h00040, 16'h1111);
        if16.pm_core_rd_addr = 17'h00040;
        tick();
        check_eq("collision old", if16.pm_core_rd_data, 32'h2222);
        a16(1'b0, 1'b0, 17'h00040, 16'h0);
        tick();
        check_eq("collision new", if16.pm_core_rd_data, 32'h1111);

        // Hold: port A data stays put while idle and across a write pulse.
        a16(1'b1, 1'b1, 17'h00200, 16'hBEEF); tick();
        a16(1'b1, 1'b0, 17'h00200, 16'h0);    tick();
        check_eq("hold read", if16.pm_rd_data, 32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            a16(1'b0, i[0], 17'h00123, 16'h0);
            tick();
            check_eq($sformatf("hold ce=0 #%0d", i), if16.pm_rd_data, 32'hBEEF);
        end
        a16(1'b1, 1'b1, 17'h00200, 16'h1234); tick();
        check_eq("hold on write", if16.pm_rd_data, 32'hBEEF);
        a16(1'b0, 1'b1, 17'h00201, 16'hDEAD); tick();
        a16(1'b1, 1'b0, 17'h00201, 16'h0);    tick();
        check_eq("wr without ce ignored", if16.pm_rd_data, 32'h5555);
        a16(1'b1, 1'b0, 17'h00200, 16'h0);    tick();
        check_eq("write pulse landed", if16.pm_rd_data, 32'h1234);

        // Wrap and range checks at PM_SIZE=16.
        a16(1'b1, 1'b0, 17'h04000, 16'h0);
        if16.pm_core_rd_addr = 17'h04000;
        tick();
        check_eq("wrap A 0x4000 data",  if16.pm_rd_data, 32'h0F0F);
        check_eq("wrap A 0x4000 err",   if16.pm_addr_err, 32'(RC));
        check_eq("wrap B 0x4000 data",  if16.pm_core_rd_data, 32'h0F0F);
        check_eq("wrap B 0x4000 err",   if16.pm_core_addr_err, 32'h0);
        a16(1'b0, 1'b0, 17'h1FFFF, 16'h0);
        if16.pm_core_rd_addr = 17'h04001;
        tick();
        check_eq("A err pulse ends",    if16.pm_addr_err, 32'h0);
        check_eq("wrap B 0x4001 data",  if16.pm_core_rd_data, 32'h1357);
        check_eq("wrap B 0x4001 err",   if16.pm_core_addr_err, 32'(RC));
        if16.pm_core_rd_addr = 17'h1FFFF;
        tick();
        check_eq("wrap B 0x1FFFF data", if16.pm_core_rd_data, 32'hC0DE);
        check_eq("wrap B 0x1FFFF err",  if16.pm_core_addr_err, 32'(RC));
        check_eq("A ce=0 no err",       if16.pm_addr_err, 32'h0);
        if16.pm_core_rd_addr = 17'h00000;
        tick();
        check_eq("B err not sticky",    if16.pm_core_addr_err, 32'h0);

        // Asynchronous reset in the middle of the stream.
        a16(1'b1, 1'b0, 17'h04000, 16'h0);
        if16.pm_core_rd_addr = 17'h04001;
        tick();
        check_eq("pre-rst rd_data",   if16.pm_rd_data, 32'h0F0F);
        check_eq("pre-rst core data", if16.pm_core_rd_data, 32'h1357);
        #2;
        rst_flash_n = 1'b0;
        #1;
        check_eq("async rst rd_data",       if16.pm_rd_data, 32'h0);
        check_eq("async rst core_rd_data",  if16.pm_core_rd_data, 32'h0);
        check_eq("async rst addr_err",      if16.pm_addr_err, 32'h0);
        check_eq("async rst core_addr_err", if16.pm_core_addr_err, 32'h0);
        a16(1'b1, 1'b1, 17'h00123, 16'hFFFF);
        tick();
        check_eq("in-rst rd_data held",   if16.pm_rd_data, 32'h0);
        check_eq("in-rst core data held", if16.pm_core_rd_data, 32'h0);
        rst_flash_n = 1'b1;
        a16(1'b1, 1'b0, 17'h00123, 16'h0);
        if16.pm_core_rd_addr = 17'h00040;
        tick();
        check_eq("post-rst 0x123 intact", if16.pm_rd_data, 32'hA5C3);
        check_eq("post-rst 0x040 intact", if16.pm_core_rd_data, 32'h1111);
        a16(1'b0, 1'b0, 17'h0, 16'h0);

        // PM_SIZE=32: the extreme addresses are distinct, and 0x8000 aliases to word 0.
        a32(1'b1, 1'b1, 17'h07FFF, 16'hAAAA); tick();
        a32(1'b1, 1'b1, 17'h00000, 16'h5A5A); tick();
        a32(1'b1, 1'b0, 17'h07FFF, 16'h0);
        if32.pm_core_rd_addr = 17'h00000;
        tick();
        check_eq("x32 A 0x7FFF",     if32.pm_rd_data, 32'hAAAA);
        check_eq("x32 B 0x0000",     if32.pm_core_rd_data, 32'h5A5A);
        check_eq("x32 A 0x7FFF err", if32.pm_addr_err, 32'h0);
        a32(1'b1, 1'b0, 17'h08000, 16'h0);
        if32.pm_core_rd_addr = 17'h08000;
        tick();
        check_eq("x32 A 0x8000 alias", if32.pm_rd_data, 32'h5A5A);
        check_eq("x32 A 0x8000 err",   if32.pm_addr_err, 32'(RC));
        check_eq("x32 B 0x8000 alias", if32.pm_core_rd_data, 32'h5A5A);
        check_eq("x32 B 0x8000 err",   if32.pm_core_addr_err, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
